// File: rtl/ir_pkg.sv
// Shared types and ir_command byte-lane positions for the IR key-event path.
package ir_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_REPEAT  = 2'd1,
    EV_RELEASE = 2'd2
  } ev_type_e;

  localparam int CMD_LSB   = 24;
  localparam int CMDN_LSB  = 16;
  localparam int ADDR_LSB  = 8;
  localparam int ADDRN_LSB = 0;

  typedef struct packed {
    ev_type_e   ev_type;
    logic [7:0] addr;
    logic [7:0] cmd;
  } ev_t;

  function automatic logic [7:0] lane(input logic [31:0] w, input int lsb);
    return w[lsb +: 8];
  endfunction

  // NEC frames carry each byte followed by its bitwise complement.
  function automatic logic frame_ok(input logic [31:0] w);
    return (lane(w, CMD_LSB) == ~lane(w, CMDN_LSB)) &&
           (lane(w, ADDR_LSB) == ~lane(w, ADDRN_LSB));
  endfunction

  function automatic ev_t make_ev(input ev_type_e t, input logic [15:0] code);
    ev_t e;
    e.ev_type = t;
    e.addr    = code[15:8];
    e.cmd     = code[7:0];
    return e;
  endfunction

endpackage

// File: rtl/ir_event_fifo.sv
// Event FIFO with a registered head entry; entries behind the head live in a
// small array, so total capacity is DEPTH (head + DEPTH-1 stored).
module ir_event_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  ev_t  push_data,
  input  logic pop,
  output ev_t  head_data,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  ev_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          head_valid_q, head_valid_d;
  ev_t           head_q, head_d;
  logic          do_pop, accept, mem_we;

  always_comb begin
    do_pop       = head_valid_q & pop;
    full         = head_valid_q && (cnt_q == AW'(DEPTH - 1));
    accept       = push && (!full || do_pop);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    mem_we       = 1'b0;

    if (!head_valid_q) begin
      if (accept) begin
        head_valid_d = 1'b1;
        head_d       = push_data;
      end
    end else if (do_pop) begin
      if (cnt_q != '0) begin
        // Refill the head from storage; a concurrent push takes the freed slot.
        head_d   = mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end else if (accept) begin
        head_d = push_data;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign head_data = head_q;
  assign empty     = ~head_valid_q;

endmodule

// File: rtl/ir_key_event.sv
// Turns decoded NEC frames into PRESS/REPEAT/RELEASE key events, buffered in a
// FIFO behind a valid/ready handshake.
module ir_key_event
  import ir_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int RELEASE_TIMEOUT = 110000,
  parameter int ERR_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ir_ready,
  input  logic [31:0]      ir_command,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_type,
  output logic [7:0]       ev_addr,
  output logic [7:0]       ev_cmd,
  output logic             key_held,
  output logic             overflow,
  output logic [ERR_W-1:0] err_count
);

  localparam int TW = $clog2(RELEASE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RELEASE_TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic             ir_ready_q, ir_ready_d;
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [15:0]      code_q, code_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_cmd_q, pend_cmd_d;
  logic             push_q, push_d;
  ev_t              push_ev_q, push_ev_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ovf_q, ovf_d;

  logic        strobe, frame_vld, frame_good, pop;
  logic [31:0] frame_w;
  logic [15:0] frame_code;
  logic        fifo_empty, fifo_full;
  ev_t         head;

  always_comb begin
    ir_ready_d = ir_ready;
    strobe     = ir_ready & ~ir_ready_q & enable;

    // A strobe landing in EMIT_PRESS is parked and replayed on the next cycle.
    frame_vld  = 1'b0;
    frame_w    = ir_command;
    if (state_q != ST_EMIT) begin
      frame_vld = pend_q | strobe;
      frame_w   = pend_q ? pend_cmd_q : ir_command;
    end
    frame_good = frame_ok(frame_w);
    frame_code = {lane(frame_w, ADDR_LSB), lane(frame_w, CMD_LSB)};

    state_d    = state_q;
    timer_d    = (state_q == ST_HELD && timer_q != '0) ? timer_q - TW'(1) : timer_q;
    code_d     = code_q;
    pend_d     = 1'b0;
    pend_cmd_d = pend_cmd_q;
    push_d     = 1'b0;
    push_ev_d  = push_ev_q;
    err_d      = err_q;

    if (state_q == ST_EMIT && strobe) begin
      pend_d     = 1'b1;
      pend_cmd_d = ir_command;
    end

    if (frame_vld && !frame_good && err_q != '1) begin
      err_d = err_q + ERR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_vld && frame_good) begin
          push_d    = 1'b1;
          push_ev_d = make_ev(EV_PRESS, frame_code);
          code_d    = frame_code;
          timer_d   = TIMER_LOAD;
          state_d   = ST_HELD;
        end
      end
      ST_HELD: begin
        // A valid frame in the expiry cycle takes priority over the timeout.
        if (frame_vld && frame_good) begin
          push_d = 1'b1;
          if (frame_code == code_q) begin
            push_ev_d = make_ev(EV_REPEAT, code_q);
            timer_d   = TIMER_LOAD;
          end else begin
            push_ev_d = make_ev(EV_RELEASE, code_q);
            code_d    = frame_code;
            state_d   = ST_EMIT;
          end
        end else if (timer_q == '0) begin
          push_d    = 1'b1;
          push_ev_d = make_ev(EV_RELEASE, code_q);
          timer_d   = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_EMIT: begin
        push_d    = 1'b1;
        push_ev_d = make_ev(EV_PRESS, code_q);
        timer_d   = TIMER_LOAD;
        state_d   = ST_HELD;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    pop   = ~fifo_empty & ev_ready;
    ovf_d = ovf_q | (push_q & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_ready_q <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      code_q     <= '0;
      pend_q     <= 1'b0;
      pend_cmd_q <= '0;
      push_q     <= 1'b0;
      push_ev_q  <= '0;
      err_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ir_ready_q <= ir_ready_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
      pend_q     <= pend_d;
      pend_cmd_q <= pend_cmd_d;
      push_q     <= push_d;
      push_ev_q  <= push_ev_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  ir_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_ev_q),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign ev_valid  = ~fifo_empty;
  assign ev_type   = head.ev_type;
  assign ev_addr   = head.addr;
  assign ev_cmd    = head.cmd;
  assign key_held  = (state_q == ST_HELD);
  assign overflow  = ovf_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ir_key_event.sv
// Directed and randomized frames against a queue-based key-event model.
module tb_ir_key_event;
  import ir_pkg::*;

  localparam int DEPTH = 4;
  localparam int T     = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_command = '0;
  logic        ev_ready;
  logic        ev_valid, key_held, overflow;
  logic [1:0]  ev_type;
  logic [7:0]  ev_addr, ev_cmd, err_count;

  always #5 clk = ~clk;

  ir_key_event #(
    .FIFO_DEPTH      (DEPTH),
    .RELEASE_TIMEOUT (T),
    .ERR_W           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ir_ready   (ir_ready),
    .ir_command (ir_command),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_type    (ev_type),
    .ev_addr    (ev_addr),
    .ev_cmd     (ev_cmd),
    .key_held   (key_held),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [17:0] exp_q[$];
  bit          m_held = 0;
  logic [15:0] m_code = '0;
  int          load_cyc = -1;
  int          m_err = 0;
  bit          m_ovf = 0;
  bit          auto_exp = 1;
  bit          rand_ready = 0;
  bit          ready_ctl = 1;

  localparam logic [31:0] FA = 32'h10EF_20DF;
  localparam logic [31:0] FB = 32'h08F7_20DF;
  localparam logic [31:0] FC = 32'h45BA_00FF;
  localparam logic [31:0] FBAD = 32'h10EE_20DF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [1:0] t, input logic [15:0] code);
    if (exp_q.size() < DEPTH) exp_q.push_back({t, code});
    else m_ovf = 1;
  endtask

  task automatic model_frame(input logic [31:0] w);
    logic [15:0] c;
    c = {w[15:8], w[31:24]};
    if (!enable) return;
    if (w[31:24] != ~w[23:16] || w[15:8] != ~w[7:0]) begin
      if (m_err < 255) m_err++;
      return;
    end
    if (!m_held) push_exp(EV_PRESS, c);
    else if (c == m_code) push_exp(EV_REPEAT, c);
    else begin
      push_exp(EV_RELEASE, m_code);
      push_exp(EV_PRESS, c);
    end
    m_held   = 1;
    m_code   = c;
    load_cyc = cyc;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      // Key released well before the timeout could fire; model records it early.
      if (auto_exp && m_held && load_cyc >= 0 && cyc - load_cyc == T - 20) begin
        push_exp(EV_RELEASE, m_code);
        m_held = 0;
      end
    end
  endtask

  task automatic frame_pulse(input logic [31:0] w);
    ir_command = w;
    ir_ready   = 1'b1;
    model_frame(w);
    tick(1);
    ir_ready   = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    m_held = 0; m_err = 0; m_ovf = 0; load_cyc = -1;
    tick(1);
  endtask

  // Consumer: picks ev_ready for the coming edge and scores every accepted event.
  initial begin
    logic [17:0] e;
    ev_ready = 1'b0;
    forever begin
      @(negedge clk);
      ev_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_ctl;
      if (ev_valid && ev_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_event got=%0h want=none", {ev_type, ev_addr, ev_cmd});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("event", {14'd0, ev_type, ev_addr, ev_cmd}, {14'd0, e});
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    int gap;
    do_reset();
    chk("rst_outs", {23'd0, ev_valid, ev_type, ev_addr, ev_cmd, key_held, overflow},
        32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);

    // PRESS latency and key_held
    frame_pulse(FA);
    chk("press_lat_e1", {31'd0, ev_valid}, 32'd0);
    chk("press_held", {31'd0, key_held}, 32'd1);
    tick(1);
    chk("press_valid", {31'd0, ev_valid}, 32'd1);
    chk("press_ev", {14'd0, ev_type, ev_addr, ev_cmd}, {14'd0, 2'd0, 8'h20, 8'h10});

    // REPEAT then RELEASE exactly T+1 cycles after the REPEAT write
    tick(5);
    frame_pulse(FA);
    tick(1);
    chk("repeat_type", {30'd0, ev_type}, 32'd1);
    tick(T);
    chk("rel_not_yet", {31'd0, ev_valid}, 32'd0);
    tick(1);
    chk("rel_valid", {31'd0, ev_valid}, 32'd1);
    chk("rel_ev", {14'd0, ev_type, ev_addr, ev_cmd}, {14'd0, 2'd2, 8'h20, 8'h10});
    chk("rel_held", {31'd0, key_held}, 32'd0);

    // New code while held: RELEASE old then PRESS new on consecutive writes
    tick(5);
    frame_pulse(FA);
    tick(5);
    frame_pulse(FB);
    tick(1);
    chk("chg_rel", {14'd0, ev_type, ev_addr, ev_cmd}, {14'd0, 2'd2, 8'h20, 8'h10});
    tick(1);
    chk("chg_press", {14'd0, ev_type, ev_addr, ev_cmd}, {14'd0, 2'd0, 8'h20, 8'h08});

    // Inversion failures and counter saturation
    do_reset();
    frame_pulse(FBAD);
    tick(3);
    chk("bad_err1", {24'd0, err_count}, 32'(m_err));
    chk("bad_noev", {31'd0, ev_valid}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      frame_pulse(FBAD);
      tick(1);
    end
    tick(2);
    chk("err_sat", {24'd0, err_count}, 32'd255);

    // Overflow with a stalled consumer, then drain in order
    do_reset();
    ready_ctl = 0;
    for (int i = 1; i <= 6; i++) begin
      w = {8'(i), ~8'(i), 8'h20, 8'hDF};
      frame_pulse(w);
      tick(5);
    end
    chk("ovf_flag", {31'd0, overflow}, {31'd0, m_ovf});
    chk("ovf_head", {13'd0, ev_valid, ev_type, ev_addr, ev_cmd},
        {13'd0, 1'b1, 2'd0, 8'h20, 8'h01});
    ready_ctl = 1;
    tick(10);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Ready held high: one PRESS, later the timeout RELEASE, nothing else
    do_reset();
    ir_command = FA;
    ir_ready   = 1'b1;
    model_frame(FA);
    tick(1000);
    ir_ready   = 1'b0;
    tick(5);
    chk("hold_high", 32'(exp_q.size()), 32'd0);

    // Frames ignored while disabled
    enable = 1'b0;
    frame_pulse(FA);
    tick(10);
    chk("dis_noev", {31'd0, ev_valid}, 32'd0);
    chk("dis_held", {31'd0, key_held}, 32'd0);
    enable = 1'b1;

    // Reset while HELD: no RELEASE afterwards
    frame_pulse(FA);
    tick(5);
    chk("pre_rst_held", {31'd0, key_held}, 32'd1);
    do_reset();
    chk("mid_rst_outs", {23'd0, ev_valid, ev_type, ev_addr, ev_cmd, key_held, overflow},
        32'd0);
    tick(T + 50);
    chk("mid_rst_norel", {31'd0, ev_valid}, 32'd0);

    // Frame in the expiry cycle wins; one cycle later gives RELEASE then PRESS
    auto_exp = 0;
    frame_pulse(FA);
    tick(T);
    frame_pulse(FA);
    tick(T + 1);
    push_exp(EV_RELEASE, m_code);
    m_held = 0;
    frame_pulse(FA);
    auto_exp = 1;
    tick(T + 50);
    chk("expiry_edge", 32'(exp_q.size()), 32'd0);

    // Randomized traffic
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: w = FA;
        1: w = FB;
        default: w = FC;
      endcase
      if ($urandom_range(0, 4) == 0) w = w ^ (32'h1 << (16 + $urandom_range(0, 7)));
      enable = ($urandom_range(0, 6) != 0);
      frame_pulse(w);
      enable = 1'b1;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(T + 20, T + 80)
                                         : $urandom_range(20, T - 40);
      tick(gap);
      while (load_cyc >= 0 && cyc - load_cyc >= T - 30 && cyc - load_cyc <= T + 15) tick(1);
    end
    tick(T + 60);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_err", {24'd0, err_count}, 32'(m_err));
    chk("rand_ovf", {31'd0, overflow}, {31'd0, m_ovf});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
